// File: rtl/dsp_pkg.sv
// Shared types and constants for the fir control plane.
// Holds the sequencer state encoding, default widths and a tap-index width helper.
package dsp_pkg;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    function automatic int tap_idx_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow coefficient register file: one synchronous write port and one asynchronous read port.
// Every entry clears on reset so an unconfigured bank loads all-zero coefficients.
module fir_coeff_bank #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/fir_cfg_sequencer.sv
// Reload sequencer for the fir datapath: stalls the stream, streams every coefficient slot into fir,
// optionally flushes the delay line with zeros, then reopens the stream.
module fir_cfg_sequencer
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int COEF_WIDTH = COEF_W,
    parameter int MAX_TAPS   = 8,
    parameter bit FLUSH_EN   = 1'b1,
    localparam int IDX_W     = tap_idx_w(MAX_TAPS),
    localparam int NUM_W     = IDX_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_wr_en,
    input  logic [IDX_W-1:0]      cfg_index,
    input  logic [COEF_WIDTH-1:0] cfg_value,
    input  logic [NUM_W-1:0]      cfg_num_taps,
    input  logic                  cfg_commit,
    output logic                  cfg_busy,
    output logic                  cfg_err,
    output logic                  load_done,
    input  logic [DATA_WIDTH-1:0] s_din,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] fir_din,
    output logic                  fir_din_valid,
    output logic                  fir_coeff_wr_en,
    output logic [IDX_W-1:0]      fir_coeff_index,
    output logic [COEF_WIDTH-1:0] fir_coeff_value,
    output logic [1:0]            dbg_state
);

    state_e                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_W-1:0]      r_n;
    logic                  r_load_done;
    logic                  r_err;

    logic                  w_load;
    logic                  w_flush;
    logic                  w_run;
    logic                  w_busy;
    logic                  w_wr_accept;
    logic                  w_commit_accept;
    logic                  w_last;
    logic [NUM_W-1:0]      w_n_sat;
    logic [COEF_WIDTH-1:0] w_shadow_q;

    assign w_load          = (r_state == ST_LOAD);
    assign w_flush         = (r_state == ST_FLUSH);
    assign w_run           = (r_state == ST_RUN);
    assign w_busy          = w_load | w_flush;
    assign w_wr_accept     = cfg_wr_en & ~w_busy;
    assign w_commit_accept = cfg_commit & ~w_busy;
    assign w_last          = (r_idx == IDX_W'(MAX_TAPS - 1));
    assign w_n_sat         = (cfg_num_taps > NUM_W'(MAX_TAPS)) ? NUM_W'(MAX_TAPS) : cfg_num_taps;

    // A write in the commit cycle lands at the same edge, so LOAD slot 0 already sees it.
    fir_coeff_bank #(
        .DEPTH (MAX_TAPS),
        .WIDTH (COEF_WIDTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_accept),
        .i_wr_idx  (cfg_index),
        .i_wr_data (cfg_value),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_shadow_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_n         <= '0;
            r_load_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_err       <= w_busy & (cfg_wr_en | cfg_commit);
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_commit_accept) begin
                        r_state <= ST_LOAD;
                        r_idx   <= '0;
                        r_n     <= w_n_sat;
                    end
                end
                ST_LOAD: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        if (FLUSH_EN) begin
                            r_state <= ST_FLUSH;
                        end else begin
                            r_state     <= ST_RUN;
                            r_load_done <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_state     <= ST_RUN;
                        r_load_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Slots at or beyond the active tap count are written as zero.
    assign fir_coeff_wr_en = w_load;
    assign fir_coeff_index = w_load ? r_idx : '0;
    assign fir_coeff_value = (w_load && ({1'b0, r_idx} < r_n)) ? w_shadow_q : '0;

    assign s_ready       = w_run;
    assign fir_din       = w_run ? s_din : '0;
    assign fir_din_valid = w_flush | (w_run & s_valid);

    assign cfg_busy  = w_busy;
    assign cfg_err   = r_err;
    assign load_done = r_load_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// Directed bench for fir_cfg_sequencer (MAX_TAPS=8, FLUSH_EN=1): reload timing, tap count handling,
// busy rejection, stream stall around a commit, and reset during LOAD.
module tb_fir_cfg_sequencer;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NT = 8;
    localparam int IW = 3;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_wr_en;
    logic [IW-1:0] cfg_index;
    logic [CW-1:0] cfg_value;
    logic [NW-1:0] cfg_num_taps;
    logic          cfg_commit;
    logic          cfg_busy;
    logic          cfg_err;
    logic          load_done;
    logic [DW-1:0] s_din;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] fir_din;
    logic          fir_din_valid;
    logic          fir_coeff_wr_en;
    logic [IW-1:0] fir_coeff_index;
    logic [CW-1:0] fir_coeff_value;
    logic [1:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [CW-1:0] shadow_m [NT];
    logic [CW-1:0] exp_coef [NT];

    // busy, err, load_done, s_ready, din_valid, din, coeff_wr_en, coeff_index, coeff_value
    logic [40:0] obs;
    assign obs = {cfg_busy, cfg_err, load_done, s_ready, fir_din_valid, fir_din,
                  fir_coeff_wr_en, fir_coeff_index, fir_coeff_value};

    fir_cfg_sequencer #(
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .MAX_TAPS   (NT),
        .FLUSH_EN   (1'b1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_index       (cfg_index),
        .cfg_value       (cfg_value),
        .cfg_num_taps    (cfg_num_taps),
        .cfg_commit      (cfg_commit),
        .cfg_busy        (cfg_busy),
        .cfg_err         (cfg_err),
        .load_done       (load_done),
        .s_din           (s_din),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .fir_din         (fir_din),
        .fir_din_valid   (fir_din_valid),
        .fir_coeff_wr_en (fir_coeff_wr_en),
        .fir_coeff_index (fir_coeff_index),
        .fir_coeff_value (fir_coeff_value),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cfg();
        cfg_wr_en    = 1'b0;
        cfg_commit   = 1'b0;
        cfg_index    = '0;
        cfg_value    = '0;
        cfg_num_taps = '0;
    endtask

    task automatic write_shadow(input int k, input logic [CW-1:0] v);
        cfg_wr_en = 1'b1;
        cfg_index = IW'(k);
        cfg_value = v;
        shadow_m[k] = v;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    // Commit with ntaps, then check every LOAD/FLUSH cycle plus the first two RUN cycles.
    // A negative inj_*_k disables the busy-time commit (LOAD) or write (FLUSH) injection.
    task automatic run_seq(input string name, input int ntaps, input int inj_load_k, input int inj_flush_k);
        logic [40:0] exp_v;
        bit          prev_inj;
        bit          inj;
        bit          in_load;
        int          k;
        int          n_eff;
        n_eff = (ntaps > NT) ? NT : ntaps;
        for (int i = 0; i < NT; i++) begin
            exp_coef[i] = (i < n_eff) ? shadow_m[i] : '0;
        end
        prev_inj     = 1'b0;
        cfg_commit   = 1'b1;
        cfg_num_taps = NW'(ntaps);
        tick();
        cfg_commit = 1'b0;
        for (int c = 0; c < 2 * NT; c++) begin
            in_load      = (c < NT);
            k            = c % NT;
            inj          = (in_load && k == inj_load_k) || (!in_load && k == inj_flush_k);
            cfg_commit   = in_load & inj;
            cfg_wr_en    = ~in_load & inj;
            cfg_index    = '0;
            cfg_value    = 16'hAAAA;
            cfg_num_taps = 4'd1;
            #1;
            exp_v = {1'b1, prev_inj, 1'b0, 1'b0, ~in_load, 16'h0000,
                     in_load, (in_load ? IW'(k) : IW'(0)), (in_load ? exp_coef[k] : 16'h0000)};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL %s cycle %0d: got %h want %h", name, c + 1, obs, exp_v);
            end
            prev_inj = inj;
            tick();
        end
        clear_cfg();
        #1;
        exp_v = {1'b0, prev_inj, 1'b1, 1'b1, s_valid, s_din, 1'b0, 3'd0, 16'h0000};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s first_run: got %h want %h", name, obs, exp_v);
        end
        tick();
        exp_v = {1'b0, 1'b0, 1'b0, 1'b1, s_valid, s_din, 1'b0, 3'd0, 16'h0000};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s second_run: got %h want %h", name, obs, exp_v);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_din   = 16'h1234;
        clear_cfg();
        for (int i = 0; i < NT; i++) begin
            shadow_m[i] = '0;
        end
        for (int c = 0; c < 6; c++) begin
            if (c == 3) rst_n = 1'b1;
            tick();
            n_vec++;
            if (obs !== 41'd0 || dbg_state !== 2'd0) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d: got %h/%0d want 0/0", c, obs, dbg_state);
            end
        end
    endtask

    task automatic test_load_full();
        s_din = 16'h5A5A;
        for (int k = 0; k < NT; k++) begin
            write_shadow(k, CW'(k + 1));
        end
        run_seq("load_n8", 8, -1, -1);
    endtask

    task automatic test_num_taps();
        run_seq("load_n3", 3, -1, -1);
        run_seq("load_n15", 15, -1, -1);
        run_seq("load_n0", 0, -1, -1);
    endtask

    task automatic test_write_with_commit();
        cfg_wr_en   = 1'b1;
        cfg_index   = 3'd2;
        cfg_value   = 16'h0777;
        shadow_m[2] = 16'h0777;
        run_seq("wr_commit_same", 8, -1, -1);
    endtask

    task automatic test_busy_reject();
        run_seq("reject", 8, 2, 3);
        run_seq("after_reject_n1", 1, -1, -1);
    endtask

    task automatic test_stream_commit();
        int cur;
        int stalls;
        bit commit_done;
        cur         = 1;
        stalls      = 0;
        commit_done = 1'b0;
        s_valid     = 1'b1;
        for (int c = 0; c < 80 && cur <= 20; c++) begin
            s_din        = DW'(cur);
            cfg_commit   = (cur == 10) && !commit_done;
            cfg_num_taps = 4'd8;
            #1;
            if (s_ready) begin
                n_vec++;
                if ({fir_din_valid, fir_din} !== {1'b1, DW'(cur)}) begin
                    n_err++;
                    $display("FAIL stream sample %0d: got %b/%0d want 1/%0d", cur, fir_din_valid, fir_din, cur);
                end
                if (cfg_commit) commit_done = 1'b1;
                cur++;
            end else begin
                stalls++;
            end
            tick();
        end
        clear_cfg();
        n_vec++;
        if (cur !== 21 || stalls !== 16) begin
            n_err++;
            $display("FAIL stream_totals: got next=%0d stalls=%0d want next=21 stalls=16", cur, stalls);
        end
        s_valid = 1'b0;
        #1;
        n_vec++;
        if ({s_ready, fir_din_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL stream_no_valid: got %b want 10", {s_ready, fir_din_valid});
        end
        s_valid = 1'b1;
    endtask

    task automatic test_reset_mid_load();
        cfg_commit   = 1'b1;
        cfg_num_taps = 4'd8;
        tick();
        clear_cfg();
        repeat (4) tick();
        n_vec++;
        if ({fir_coeff_wr_en, fir_coeff_index, cfg_busy} !== {1'b1, 3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL mid_load_pre: got %b want 11001", {fir_coeff_wr_en, fir_coeff_index, cfg_busy});
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== 41'd0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL mid_load_reset: got %h/%0d want 0/0", obs, dbg_state);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NT; i++) begin
            shadow_m[i] = '0;
        end
        tick();
        n_vec++;
        if (obs !== 41'd0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: got %h/%0d want 0/0", obs, dbg_state);
        end
        run_seq("post_reset_load", 8, -1, -1);
    endtask

    initial begin
        test_reset();
        test_load_full();
        test_num_taps();
        test_write_with_commit();
        test_busy_reject();
        test_stream_commit();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout want completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
